hist_eq_cfg_ctrl: RTL and testbench

Frame-synchronous configuration controller for `hist_eq_module`. It accepts parameter writes from a control bus into a pending shadow set and checks them on commit. It applies the committed set to `hist_eq_module` only at an accepted start-of-frame beat, so contrast and bound parameters never change mid-frame. It also monitors the module's input AXI4-Stream for frame/line structure errors.

---
 rtl/hist_eq_cfg_ctrl_if.sv | 25 ++
 rtl/hist_eq_cfg_ctrl.sv | 156 +++++++++++++++
 tb/tb_hist_eq_cfg_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_eq_cfg_ctrl_if.sv
// Control-bus and monitored-stream bundle for hist_eq_cfg_ctrl.
// The master drives writes/commits and the observed stream; the controller is the slave.
interface hist_eq_cfg_ctrl_if;
    logic        cfg_wr_valid;
    logic        cfg_wr_ready;
    logic [1:0]  cfg_wr_addr;
    logic [15:0] cfg_wr_data;
    logic        cfg_commit;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_tuser;
    logic        mon_tlast;

    modport master (
        output cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_commit,
        output mon_tvalid, mon_tready, mon_tuser, mon_tlast,
        input  cfg_wr_ready
    );

    modport slave (
        input  cfg_wr_valid, cfg_wr_addr, cfg_wr_data, cfg_commit,
        input  mon_tvalid, mon_tready, mon_tuser, mon_tlast,
        output cfg_wr_ready
    );
endinterface

// File: rtl/hist_eq_cfg_ctrl.sv
// Frame-synchronous parameter controller for hist_eq_module; stats counters under HIST_EQ_CFG_STATS_EN.
// States: IDLE = no frame seen yet, commits apply at once | STREAM = commits wait for the next SOF beat.
module hist_eq_cfg_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int BOUND_WIDTH     = 10,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       i_sys_clk,
    input  logic                       i_sys_aresetn,
    hist_eq_cfg_ctrl_if.slave          bus,
    output logic [DATA_WIDTH-1:0]      contrast_threshold_param,
    output logic [BOUND_WIDTH-1:0]     upper_bound_param,
    output logic [BOUND_WIDTH-1:0]     lower_bound_param,
    output logic                       thresholding_en,
    output logic                       cfg_pending,
    output logic                       cfg_applied,
    output logic                       cfg_err,
    output logic                       err_early_sof,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic [FRAME_CNT_WIDTH-1:0] last_frame_lines
);

    localparam logic [DATA_WIDTH-1:0]  CONTRAST_RST = DATA_WIDTH'(170);
    localparam logic [BOUND_WIDTH-1:0] UPPER_RST    = BOUND_WIDTH'(250);
    localparam logic [BOUND_WIDTH-1:0] LOWER_RST    = BOUND_WIDTH'(100);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                     state_q;
    logic [DATA_WIDTH-1:0]      p_contrast_q, p_contrast_d, a_contrast_q;
    logic [BOUND_WIDTH-1:0]     p_upper_q, p_upper_d, a_upper_q;
    logic [BOUND_WIDTH-1:0]     p_lower_q, p_lower_d, a_lower_q;
    logic                       p_thr_q, p_thr_d, a_thr_q;
    logic                       pending_q, applied_q, err_q, early_q;
    logic [FRAME_CNT_WIDTH-1:0] pix_q;
    logic                       wr_fire, commit_req, commit_bad, commit_ok, beat, sof;
    logic                       unused_wr_data;

    assign unused_wr_data = ^bus.cfg_wr_data[15:BOUND_WIDTH];

    assign wr_fire    = bus.cfg_wr_valid & ~pending_q;
    assign beat       = bus.mon_tvalid & bus.mon_tready;
    assign sof        = beat & bus.mon_tuser;

    // The commit check sees this cycle's write, so a same-cycle write is included.
    always_comb begin
        p_contrast_d = p_contrast_q;
        p_upper_d    = p_upper_q;
        p_lower_d    = p_lower_q;
        p_thr_d      = p_thr_q;
        if (wr_fire) begin
            case (bus.cfg_wr_addr)
                2'd0:    p_contrast_d = bus.cfg_wr_data[DATA_WIDTH-1:0];
                2'd1:    p_upper_d    = bus.cfg_wr_data[BOUND_WIDTH-1:0];
                2'd2:    p_lower_d    = bus.cfg_wr_data[BOUND_WIDTH-1:0];
                default: p_thr_d      = bus.cfg_wr_data[0];
            endcase
        end
    end

    assign commit_req = bus.cfg_commit & ~pending_q;
    assign commit_bad = commit_req & (p_lower_d > p_upper_d);
    assign commit_ok  = commit_req & ~commit_bad;

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_aresetn) begin
            state_q      <= IDLE;
            p_contrast_q <= CONTRAST_RST;
            p_upper_q    <= UPPER_RST;
            p_lower_q    <= LOWER_RST;
            p_thr_q      <= 1'b0;
            a_contrast_q <= CONTRAST_RST;
            a_upper_q    <= UPPER_RST;
            a_lower_q    <= LOWER_RST;
            a_thr_q      <= 1'b0;
            pending_q    <= 1'b0;
            applied_q    <= 1'b0;
            err_q        <= 1'b0;
            early_q      <= 1'b0;
            pix_q        <= '0;
        end else begin
            p_contrast_q <= p_contrast_d;
            p_upper_q    <= p_upper_d;
            p_lower_q    <= p_lower_d;
            p_thr_q      <= p_thr_d;
            applied_q    <= 1'b0;
            err_q        <= commit_bad;
            early_q      <= sof & (pix_q != '0);
            case (state_q)
                IDLE: begin
                    if (commit_ok) begin
                        a_contrast_q <= p_contrast_d;
                        a_upper_q    <= p_upper_d;
                        a_lower_q    <= p_lower_d;
                        a_thr_q      <= p_thr_d;
                        applied_q    <= 1'b1;
                    end
                    if (sof) state_q <= STREAM;
                end
                STREAM: begin
                    // Pending regs are frozen while a commit waits, so _q is the committed set.
                    if (sof && pending_q) begin
                        a_contrast_q <= p_contrast_q;
                        a_upper_q    <= p_upper_q;
                        a_lower_q    <= p_lower_q;
                        a_thr_q      <= p_thr_q;
                        pending_q    <= 1'b0;
                        applied_q    <= 1'b1;
                    end else if (commit_ok) begin
                        pending_q    <= 1'b1;
                    end
                end
            endcase
            if (beat) begin
                if (bus.mon_tlast)  pix_q <= '0;
                else if (sof)       pix_q <= FRAME_CNT_WIDTH'(1);
                else                pix_q <= pix_q + FRAME_CNT_WIDTH'(1);
            end
        end
    end

`ifdef HIST_EQ_CFG_STATS_EN
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, line_cnt_q, last_lines_q;

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_aresetn) begin
            frame_cnt_q  <= '0;
            line_cnt_q   <= '0;
            last_lines_q <= '0;
        end else if (sof) begin
            frame_cnt_q  <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
            last_lines_q <= line_cnt_q;
            line_cnt_q   <= bus.mon_tlast ? FRAME_CNT_WIDTH'(1) : '0;
        end else if (beat && bus.mon_tlast) begin
            line_cnt_q   <= line_cnt_q + FRAME_CNT_WIDTH'(1);
        end
    end

    assign frame_count      = frame_cnt_q;
    assign last_frame_lines = last_lines_q;
`else
    assign frame_count      = '0;
    assign last_frame_lines = '0;
`endif

    assign bus.cfg_wr_ready         = ~pending_q;
    assign contrast_threshold_param = a_contrast_q;
    assign upper_bound_param        = a_upper_q;
    assign lower_bound_param        = a_lower_q;
    assign thresholding_en          = a_thr_q;
    assign cfg_pending              = pending_q;
    assign cfg_applied              = applied_q;
    assign cfg_err                  = err_q;
    assign err_early_sof            = early_q;

endmodule

// File: tb/tb_hist_eq_cfg_ctrl.sv
// Self-checking bench for hist_eq_cfg_ctrl: directed scenarios then random traffic against a transaction-level model.
module tb_hist_eq_cfg_ctrl;
    localparam int LINE_LEN  = 16;
    localparam int FRAME_LEN = 64;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  contrast;
    logic [9:0]  upper, lower;
    logic        thr, pending, applied, err, early;
    logic [15:0] frames, last_lines;

    int checks = 0;
    int failures = 0;
    int s_pos = 0;

    // Reference state: parameter sets indexed by address (0 contrast, 1 upper, 2 lower, 3 enable)
    int m_act[4];
    int m_pset[4];
    bit m_pending, m_stream, m_applied, m_err, m_early;
    int m_pix, m_lines, m_frames, m_last_lines;

    hist_eq_cfg_ctrl_if bus();

    hist_eq_cfg_ctrl dut (
        .i_sys_clk                (clk),
        .i_sys_aresetn            (rstn),
        .bus                      (bus),
        .contrast_threshold_param (contrast),
        .upper_bound_param        (upper),
        .lower_bound_param        (lower),
        .thresholding_en          (thr),
        .cfg_pending              (pending),
        .cfg_applied              (applied),
        .cfg_err                  (err),
        .err_early_sof            (early),
        .frame_count              (frames),
        .last_frame_lines         (last_lines)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int wmask(input bit [1:0] a, input bit [15:0] d);
        case (a)
            2'd0:       return int'(d) & 255;
            2'd1, 2'd2: return int'(d) & 1023;
            default:    return int'(d) & 1;
        endcase
    endfunction

    task automatic model_reset();
        m_act  = '{170, 250, 100, 0};
        m_pset = '{170, 250, 100, 0};
        m_pending = 0; m_stream = 0; m_applied = 0; m_err = 0; m_early = 0;
        m_pix = 0; m_lines = 0; m_frames = 0; m_last_lines = 0;
    endtask

    task automatic model_edge(input bit wv, input bit [1:0] wa, input bit [15:0] wd, input bit cm,
                              input bit mv, input bit mr, input bit tu, input bit tl);
        bit beat, sof, was_pending;
        if (!rstn) begin
            model_reset();
            return;
        end
        beat = mv && mr;
        sof  = beat && tu;
        was_pending = m_pending;
        m_applied = 0; m_err = 0; m_early = 0;
        if (wv && !was_pending) m_pset[wa] = wmask(wa, wd);
        if (cm && !was_pending) begin
            if (m_pset[2] > m_pset[1]) m_err = 1;
            else if (!m_stream) begin m_act = m_pset; m_applied = 1; end
            else m_pending = 1;
        end
        if (m_stream && sof && was_pending) begin
            m_act = m_pset; m_pending = 0; m_applied = 1;
        end
        if (sof && m_pix != 0) m_early = 1;
        if (sof) m_stream = 1;
        if (beat) m_pix = tl ? 0 : (sof ? 1 : (m_pix + 1) % 65536);
        if (sof) begin
            m_frames = (m_frames + 1) % 65536;
            m_last_lines = m_lines;
            m_lines = tl ? 1 : 0;
        end else if (beat && tl) begin
            m_lines = (m_lines + 1) % 65536;
        end
    endtask

    task automatic compare_all();
        chk("contrast", 32'(contrast), 32'(m_act[0]));
        chk("upper", 32'(upper), 32'(m_act[1]));
        chk("lower", 32'(lower), 32'(m_act[2]));
        chk("thr_en", 32'(thr), 32'(m_act[3]));
        chk("pending", 32'(pending), 32'(m_pending));
        chk("wr_ready", 32'(bus.cfg_wr_ready), 32'(!m_pending));
        chk("applied", 32'(applied), 32'(m_applied));
        chk("cfg_err", 32'(err), 32'(m_err));
        chk("early_sof", 32'(early), 32'(m_early));
`ifdef HIST_EQ_CFG_STATS_EN
        chk("frame_count", 32'(frames), 32'(m_frames));
        chk("last_lines", 32'(last_lines), 32'(m_last_lines));
`else
        chk("frame_count", 32'(frames), 32'd0);
        chk("last_lines", 32'(last_lines), 32'd0);
`endif
    endtask

    task automatic cyc(input bit wv, input bit [1:0] wa, input bit [15:0] wd, input bit cm,
                       input bit mv, input bit mr);
        bit tu, tl;
        tu = (s_pos == 0);
        tl = (s_pos % LINE_LEN == LINE_LEN - 1);
        bus.cfg_wr_valid = wv; bus.cfg_wr_addr = wa; bus.cfg_wr_data = wd; bus.cfg_commit = cm;
        bus.mon_tvalid = mv; bus.mon_tready = mr; bus.mon_tuser = tu; bus.mon_tlast = tl;
        @(posedge clk);
        model_edge(wv, wa, wd, cm, mv, mr, tu, tl);
        if (!rstn) s_pos = 0;
        else if (mv && mr) s_pos = (s_pos + 1) % FRAME_LEN;
        #1;
        compare_all();
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'd0, 16'd0, 0, 1, 1);
    endtask

    task automatic do_reset();
        rstn = 0;
        cyc(0, 2'd0, 16'd0, 0, 0, 0);
        cyc(0, 2'd0, 16'd0, 0, 0, 0);
        rstn = 1;
    endtask

    task automatic stream_until_applied(input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            stream(1);
            if (applied) found = 1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic stream_to_frame_start();
        for (int i = 0; i < 200 && s_pos != 0; i++) stream(1);
        chk("align_sof", 32'(s_pos), 32'd0);
    endtask

    initial begin
        bit [1:0]  wa;
        bit [15:0] wd;
        model_reset();
        cyc(0, 2'd0, 16'd0, 0, 0, 0);
        do_reset();
        chk("rst_contrast", 32'(contrast), 32'd170);
        chk("rst_upper", 32'(upper), 32'd250);
        chk("rst_lower", 32'(lower), 32'd100);
        chk("rst_thr", 32'(thr), 32'd0);

        // IDLE: commit applies immediately
        cyc(1, 2'd0, 16'd200, 0, 0, 0);
        cyc(0, 2'd0, 16'd0, 1, 0, 0);
        chk("idle_contrast", 32'(contrast), 32'd200);
        chk("idle_applied", 32'(applied), 32'd1);
        chk("idle_no_pending", 32'(pending), 32'd0);
        cyc(0, 2'd0, 16'd0, 0, 0, 0);
        chk("idle_applied_pulse", 32'(applied), 32'd0);
        cyc(1, 2'd1, 16'hFE58, 1, 0, 0);   // 0xFE58 keeps 600 in the low 10 bits
        chk("same_cycle_wr_commit", 32'(upper), 32'd600);
        cyc(1, 2'd1, 16'd250, 1, 0, 0);

        // STREAM: mid-frame commit waits for next SOF
        stream(20);
        cyc(1, 2'd2, 16'd50, 0, 1, 1);
        cyc(0, 2'd0, 16'd0, 1, 1, 1);
        chk("mid_pending", 32'(pending), 32'd1);
        chk("mid_ready_low", 32'(bus.cfg_wr_ready), 32'd0);
        chk("mid_lower_held", 32'(lower), 32'd100);
        stream_until_applied("mid_apply_seen");
        chk("mid_apply_after_sof", 32'(s_pos), 32'd1);
        chk("mid_lower_new", 32'(lower), 32'd50);
        chk("mid_pending_clr", 32'(pending), 32'd0);

        // Rejected commit
        cyc(1, 2'd2, 16'd300, 0, 1, 1);
        cyc(0, 2'd0, 16'd0, 1, 1, 1);
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_pending", 32'(pending), 32'd0);
        chk("rej_lower", 32'(lower), 32'd50);
        stream(1);
        chk("rej_err_pulse", 32'(err), 32'd0);
        cyc(1, 2'd2, 16'd50, 0, 1, 1);

        // Commit on a SOF beat applies at the following SOF
        stream_to_frame_start();
        cyc(1, 2'd0, 16'd77, 1, 1, 1);
        chk("sofc_no_apply", 32'(applied), 32'd0);
        chk("sofc_pending", 32'(pending), 32'd1);
        chk("sofc_contrast_held", 32'(contrast), 32'd200);
        stream_until_applied("sofc_apply_seen");
        chk("sofc_apply_pos", 32'(s_pos), 32'd1);
        chk("sofc_contrast_new", 32'(contrast), 32'd77);

        // Early SOF after 5 pixels
        stream_to_frame_start();
        stream(5);
        s_pos = 0;
        stream(1);
        chk("early_pulse", 32'(early), 32'd1);
        stream(1);
        chk("early_single", 32'(early), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            wa = 2'($urandom_range(0, 3));
            case (wa)
                2'd1:    wd = 16'($urandom_range(150, 1023)) | 16'($urandom_range(0, 63) << 10);
                2'd2:    wd = 16'($urandom_range(0, 300));
                default: wd = 16'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) s_pos = 0;
            if ($urandom_range(0, 999) == 0) rstn = 0;
            cyc($urandom_range(0, 3) == 0, wa, wd, $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            rstn = 1;
        end

        // Reset while a commit is pending
        do_reset();
        stream(10);
        cyc(1, 2'd2, 16'd60, 1, 1, 1);
        chk("rstp_pending", 32'(pending), 32'd1);
        do_reset();
        chk("rstp_pending_clr", 32'(pending), 32'd0);
        chk("rstp_lower", 32'(lower), 32'd100);
        chk("rstp_ready", 32'(bus.cfg_wr_ready), 32'd1);
        cyc(1, 2'd0, 16'd99, 1, 0, 0);
        chk("rstp_idle_apply", 32'(contrast), 32'd99);
        chk("rstp_idle_applied", 32'(applied), 32'd1);

        // Statistics: three SOFs, four lines per frame
        do_reset();
        stream(2 * FRAME_LEN + 1);
`ifdef HIST_EQ_CFG_STATS_EN
        chk("stats_frames", 32'(frames), 32'd3);
        chk("stats_lines", 32'(last_lines), 32'd4);
`else
        chk("stats_frames_off", 32'(frames), 32'd0);
        chk("stats_lines_off", 32'(last_lines), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
